// File: rtl/exec_lane_pkg.sv
// Shared types for the execution lane: opcode encoding, FSM states, helpers.
package exec_lane_pkg;

  localparam int unsigned OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIVU = 4'd3,
    OP_FADD = 4'd4,
    OP_FSUB = 4'd5,
    OP_SLL  = 4'd6,
    OP_SRL  = 4'd7,
    OP_LOAD = 4'd8,
    OP_HALT = 4'd9
  } opcode_e;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_e;

  // Ops that finish in one cycle and write reg[rd] (DIVU handled separately).
  function automatic logic is_single_cycle(opcode_e op);
    return op inside {OP_ADD, OP_SUB, OP_MUL, OP_FADD, OP_FSUB, OP_SLL, OP_SRL};
  endfunction

endpackage

// File: rtl/exec_lane_if.sv
// Instruction issue and result bus of the execution lane.
interface exec_lane_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
);
  import exec_lane_pkg::*;

  localparam int unsigned REG_AW = $clog2(NREGS);
  localparam int unsigned SH_W   = $clog2(XLEN);

  logic              in_valid;
  logic              in_ready;
  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [REG_AW-1:0] rd;
  logic [SH_W-1:0]   shamt;
  logic              out_valid;
  logic [REG_AW-1:0] out_rd;
  logic [XLEN-1:0]   result;

  modport master (
    output in_valid, opcode, rs1, rs2, rd, shamt,
    input  in_ready, out_valid, out_rd, result
  );

  modport slave (
    input  in_valid, opcode, rs1, rs2, rd, shamt,
    output in_ready, out_valid, out_rd, result
  );

endinterface

// File: rtl/add.sv
// Integer adder with carry-in; subtraction is a + ~b + 1.
module add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_c
);

  assign sum_c = a + b + WIDTH'(cin);

endmodule

// File: rtl/fl32.sv
// Single-precision float adder, round-to-nearest-even, denormals flushed to zero.
module fl32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum_c
);

  logic [31:0]       x, y;
  logic              sx, sy;
  logic [7:0]        ex, ey, d;
  logic [23:0]       mx, my;
  logic [26:0]       mx_e, my_e, my_sh, sh_mask, norm;
  logic              sticky, round_up;
  logic [27:0]       acc;
  logic [4:0]        lz;
  logic signed [9:0] e_n;
  logic [24:0]       mant;

  always_comb begin
    // order by magnitude so the effective subtraction never goes negative
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    sx      = x[31];
    sy      = y[31];
    ex      = x[30:23];
    ey      = y[30:23];
    mx      = (ex == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
    my      = (ey == 8'd0) ? 24'd0 : {1'b1, y[22:0]};
    d       = ex - ey;
    mx_e    = {mx, 3'b000};
    my_e    = {my, 3'b000};
    sh_mask = '0;
    if (d >= 8'd27) begin
      my_sh  = '0;
      sticky = |my_e;
    end else begin
      my_sh   = my_e >> d;
      sh_mask = ~(27'h7FFFFFF << d);
      sticky  = |(my_e & sh_mask);
    end
    if (sx ^ sy) acc = {1'b0, mx_e} - {1'b0, my_sh | 27'(sticky)};
    else         acc = {1'b0, mx_e} + {1'b0, my_sh | 27'(sticky)};

    lz = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (acc[i]) lz = 5'(26 - i);
    end
    if (acc[27]) begin
      norm = acc[27:1] | 27'(acc[0]);
      e_n  = $signed({2'b00, ex}) + 10'sd1;
    end else begin
      norm = acc[26:0] << lz;
      e_n  = $signed({2'b00, ex}) - $signed({5'b00000, lz});
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant     = {1'b0, norm[26:3]} + 25'(round_up);
    if (mant[24]) begin
      mant = mant >> 1;
      e_n  = e_n + 10'sd1;
    end

    if (ex == 8'hFF)            sum_c = x;
    else if (!mant[23])         sum_c = 32'd0;
    else if (e_n <= 10'sd0)     sum_c = {sx, 31'd0};
    else if (e_n >= 10'sd255)   sum_c = {sx, 8'hFF, 23'd0};
    else                        sum_c = {sx, e_n[7:0], mant[22:0]};
  end

endmodule

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; first bit on the start edge.
module seq_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] rem_q, dvs_q;
  logic [XLEN-1:0] rem_src, quo_src, dvs_src, rem_n, quo_n;
  logic [XLEN:0]   trial;
  logic [CW-1:0]   cnt_q;
  logic            run_q;

  // One restoring step, sourced from the fresh operands on the start edge.
  always_comb begin
    dvs_src = start ? divisor  : dvs_q;
    rem_src = start ? '0       : rem_q;
    quo_src = start ? dividend : quotient;
    trial   = {rem_src, quo_src[XLEN-1]} - {1'b0, dvs_src};
    if (!trial[XLEN]) begin
      rem_n = trial[XLEN-1:0];
      quo_n = {quo_src[XLEN-2:0], 1'b1};
    end else begin
      rem_n = {rem_src[XLEN-2:0], quo_src[XLEN-1]};
      quo_n = {quo_src[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      dvs_q    <= '0;
      quotient <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q    <= rem_n;
        quotient <= quo_n;
        dvs_q    <= divisor;
        cnt_q    <= CW'(1);
        run_q    <= 1'b1;
      end else if (run_q) begin
        rem_q    <= rem_n;
        quotient <= quo_n;
        cnt_q    <= cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/exec_lane.sv
// Single-thread execution lane: register file, one-cycle ALU/FPU ops, iterative DIVU.
module exec_lane
  import exec_lane_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  exec_lane_if.slave                  bus,
  input  logic [NREGS-1:0][XLEN-1:0]  init_data,
  input  logic                        thread_active,
  output logic                        thread_complete,
  output logic                        busy
);

  localparam int unsigned REG_AW = $clog2(NREGS);

  logic [XLEN-1:0]   regs [NREGS];
  logic [XLEN-1:0]   op_a, op_b, add_b, add_sum, fp_sum, alu_res;
  logic              add_cin;
  opcode_e           opc;

  state_e            state, state_n;
  logic              in_ready_q, in_ready_n, busy_n;
  logic              out_valid_n, tc_n;
  logic [REG_AW-1:0] out_rd_n, rd_q, rd_n;
  logic [XLEN-1:0]   result_n;

  logic              accept, load_en, wr_en, div_start, div_done;
  logic [REG_AW-1:0] wr_addr;
  logic [XLEN-1:0]   wr_data, div_quo;

  assign opc     = opcode_e'(bus.opcode);
  assign op_a    = regs[bus.rs1];
  assign op_b    = regs[bus.rs2];
  assign accept  = bus.in_valid & in_ready_q;
  assign add_cin = (opc == OP_SUB);
  assign add_b   = (opc == OP_SUB) ? ~op_b : op_b;

  add #(.WIDTH(XLEN)) u_add (
    .a     (op_a),
    .b     (add_b),
    .cin   (add_cin),
    .sum_c (add_sum)
  );

  generate
    if (XLEN == 32) begin : g_fp
      logic [XLEN-1:0] fp_b;
      assign fp_b = (opc == OP_FSUB) ? {~op_b[XLEN-1], op_b[XLEN-2:0]} : op_b;
      fl32 u_fl32 (
        .a     (op_a),
        .b     (fp_b),
        .sum_c (fp_sum)
      );
    end else begin : g_no_fp
      assign fp_sum = '0;
    end
  endgenerate

  seq_divider #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (op_a),
    .divisor  (op_b),
    .done     (div_done),
    .quotient (div_quo)
  );

  // Result of every op that completes at its acceptance edge.
  always_comb begin
    alu_res = '0;
    case (opc)
      OP_ADD, OP_SUB:   alu_res = add_sum;
      OP_MUL:           alu_res = op_a * op_b;
      OP_DIVU:          alu_res = '1;
      OP_FADD, OP_FSUB: alu_res = fp_sum;
      OP_SLL:           alu_res = op_a << bus.shamt;
      OP_SRL:           alu_res = op_a >> bus.shamt;
      default:          alu_res = '0;
    endcase
  end

  always_comb begin
    state_n     = state;
    in_ready_n  = in_ready_q;
    busy_n      = busy;
    out_valid_n = 1'b0;
    out_rd_n    = bus.out_rd;
    result_n    = bus.result;
    tc_n        = thread_complete;
    rd_n        = rd_q;
    load_en     = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    div_start   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!thread_active) begin
            tc_n = 1'b1;
          end else if (opc == OP_HALT) begin
            tc_n = 1'b1;
          end else begin
            tc_n = 1'b0;
            if (opc == OP_LOAD) begin
              load_en = 1'b1;
            end else if (opc == OP_DIVU && op_b != '0) begin
              div_start  = 1'b1;
              rd_n       = bus.rd;
              state_n    = DIV;
              in_ready_n = 1'b0;
              busy_n     = 1'b1;
            end else if (opc == OP_DIVU || is_single_cycle(opc)) begin
              wr_en       = 1'b1;
              wr_addr     = bus.rd;
              wr_data     = alu_res;
              out_valid_n = 1'b1;
              out_rd_n    = bus.rd;
              result_n    = alu_res;
            end
          end
        end
      end
      DIV: begin
        if (div_done) begin
          wr_en       = 1'b1;
          wr_addr     = rd_q;
          wr_data     = div_quo;
          out_valid_n = 1'b1;
          out_rd_n    = rd_q;
          result_n    = div_quo;
          state_n     = IDLE;
          in_ready_n  = 1'b1;
          busy_n      = 1'b0;
          if (!thread_active) tc_n = 1'b1;
        end
      end
      default: begin
        state_n    = IDLE;
        in_ready_n = 1'b1;
        busy_n     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      in_ready_q      <= 1'b1;
      busy            <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_rd      <= '0;
      bus.result      <= '0;
      thread_complete <= 1'b1;
      rd_q            <= '0;
    end else begin
      state           <= state_n;
      in_ready_q      <= in_ready_n;
      busy            <= busy_n;
      bus.out_valid   <= out_valid_n;
      bus.out_rd      <= out_rd_n;
      bus.result      <= result_n;
      thread_complete <= tc_n;
      rd_q            <= rd_n;
    end
  end

  assign bus.in_ready = in_ready_q;

  // Register file: bulk image load wins over a single-port write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (load_en) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= init_data[i];
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_exec_lane.sv
// Directed self-checking bench for exec_lane.
module tb_exec_lane;
  import exec_lane_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic thread_active;
  logic thread_complete;
  logic busy;
  logic [NREGS-1:0][XLEN-1:0] init_data;

  int n_assert = 0;
  int n_fail   = 0;
  int cycles;
  logic stall_ok;

  exec_lane_if #(.XLEN(XLEN), .NREGS(NREGS)) bus ();

  exec_lane #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .init_data       (init_data),
    .thread_active   (thread_active),
    .thread_complete (thread_complete),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input opcode_e op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] sh);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.rd       = rd;
    bus.rs1      = rs1;
    bus.rs2      = rs2;
    bus.shamt    = sh;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic image_a();
    for (int i = 0; i < int'(NREGS); i++) init_data[i] = '0;
    init_data[1] = 32'd5;
    init_data[2] = 32'd3;
    init_data[3] = 32'd100;
  endtask

  task automatic image_b();
    for (int i = 0; i < int'(NREGS); i++) init_data[i] = '0;
    init_data[1] = 32'd100;
    init_data[2] = 32'd7;
    init_data[6] = 32'h55;
    init_data[8] = 32'h3F80_0000;
    init_data[9] = 32'h4000_0000;
  endtask

  // Count cycles spent stalled until out_valid, within a budget.
  task automatic div_wait(input int budget, output int n, output logic ok);
    n  = 0;
    ok = 1'b1;
    while (bus.out_valid !== 1'b1 && n < budget) begin
      if (busy !== 1'b1 || bus.in_ready !== 1'b0) ok = 1'b0;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.rd        = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.shamt     = '0;
    thread_active = 1'b1;
    image_a();

    cyc(3);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tc", 32'(thread_complete), 32'd1);
    rst_n = 1'b1;
    cyc(1);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_rd", 32'(bus.out_rd), 32'd0);

    issue(OP_LOAD, 5'd0, 5'd0, 5'd0, 5'd0);
    chk("load_no_valid", 32'(bus.out_valid), 32'd0);
    chk("load_tc_clear", 32'(thread_complete), 32'd0);

    issue(OP_ADD, 5'd4, 5'd1, 5'd2, 5'd0);
    chk("add_valid", 32'(bus.out_valid), 32'd1);
    chk("add_rd", 32'(bus.out_rd), 32'd4);
    chk("add_result", bus.result, 32'd8);
    issue(OP_SUB, 5'd5, 5'd1, 5'd2, 5'd0);
    chk("sub_rd", 32'(bus.out_rd), 32'd5);
    chk("sub_result", bus.result, 32'd2);
    issue(OP_ADD, 5'd6, 5'd4, 5'd5, 5'd0);
    chk("raw_result", bus.result, 32'd10);
    cyc(1);
    chk("valid_pulse_drop", 32'(bus.out_valid), 32'd0);

    issue(OP_MUL, 5'd10, 5'd1, 5'd2, 5'd0);
    chk("mul_result", bus.result, 32'd15);
    issue(OP_SLL, 5'd11, 5'd1, 5'd0, 5'd3);
    chk("sll_result", bus.result, 32'd40);
    issue(OP_SRL, 5'd12, 5'd3, 5'd0, 5'd2);
    chk("srl_result", bus.result, 32'd25);
    issue(OP_SUB, 5'd13, 5'd2, 5'd1, 5'd0);
    chk("sub_wrap", bus.result, 32'hFFFF_FFFE);

    issue(OP_HALT, 5'd1, 5'd1, 5'd1, 5'd0);
    chk("halt_tc", 32'(thread_complete), 32'd1);
    chk("halt_no_valid", 32'(bus.out_valid), 32'd0);
    issue(OP_ADD, 5'd14, 5'd1, 5'd0, 5'd0);
    chk("halt_no_write", bus.result, 32'd5);
    chk("add_tc_clear", 32'(thread_complete), 32'd0);
    issue(opcode_e'(4'd12), 5'd1, 5'd1, 5'd1, 5'd0);
    chk("nop_no_valid", 32'(bus.out_valid), 32'd0);

    image_b();
    issue(OP_LOAD, 5'd0, 5'd0, 5'd0, 5'd0);
    issue(OP_DIVU, 5'd6, 5'd1, 5'd2, 5'd0);
    bus.rs1 = 5'd2;
    bus.rs2 = 5'd8;
    bus.rd  = 5'd9;
    div_wait(100, cycles, stall_ok);
    chk("div_done", 32'(bus.out_valid), 32'd1);
    chk("div_cycles", 32'(cycles), 32'd32);
    chk("div_stall", 32'(stall_ok), 32'd1);
    chk("div_rd", 32'(bus.out_rd), 32'd6);
    chk("div_result", bus.result, 32'd14);
    chk("div_ready_back", 32'(bus.in_ready), 32'd1);
    issue(OP_ADD, 5'd15, 5'd6, 5'd0, 5'd0);
    chk("div_reg6", bus.result, 32'd14);

    issue(OP_DIVU, 5'd12, 5'd1, 5'd0, 5'd0);
    chk("div0_valid", 32'(bus.out_valid), 32'd1);
    chk("div0_result", bus.result, 32'hFFFF_FFFF);
    chk("div0_busy", 32'(busy), 32'd0);
    cyc(1);
    chk("div0_busy_after", 32'(busy), 32'd0);

    issue(OP_FADD, 5'd13, 5'd8, 5'd9, 5'd0);
    chk("fadd_result", bus.result, 32'h4040_0000);
    issue(OP_FSUB, 5'd13, 5'd8, 5'd9, 5'd0);
    chk("fsub_result", bus.result, 32'hBF80_0000);

    issue(OP_DIVU, 5'd14, 5'd1, 5'd2, 5'd0);
    cyc(10);
    rst_n = 1'b0;
    #1;
    chk("rdiv_busy", 32'(busy), 32'd0);
    chk("rdiv_valid", 32'(bus.out_valid), 32'd0);
    chk("rdiv_result", bus.result, 32'd0);
    chk("rdiv_tc", 32'(thread_complete), 32'd1);
    cyc(1);
    rst_n = 1'b1;
    #1;
    chk("rdiv_ready", 32'(bus.in_ready), 32'd1);
    div_wait(40, cycles, stall_ok);
    chk("rdiv_no_writeback", 32'(cycles), 32'd40);
    issue(OP_ADD, 5'd15, 5'd14, 5'd1, 5'd0);
    chk("rdiv_reg14", bus.result, 32'd0);

    image_a();
    issue(OP_LOAD, 5'd0, 5'd0, 5'd0, 5'd0);
    thread_active = 1'b0;
    for (int k = 0; k < 3; k++) begin
      issue(OP_ADD, 5'd1, 5'd1, 5'd2, 5'd0);
      chk("inact_no_valid", 32'(bus.out_valid), 32'd0);
      chk("inact_tc", 32'(thread_complete), 32'd1);
      chk("inact_ready", 32'(bus.in_ready), 32'd1);
    end
    thread_active = 1'b1;
    issue(OP_ADD, 5'd4, 5'd1, 5'd0, 5'd0);
    chk("inact_reg1_kept", bus.result, 32'd5);
    issue(OP_HALT, 5'd0, 5'd0, 5'd0, 5'd0);
    chk("halt2_tc", 32'(thread_complete), 32'd1);

    image_b();
    issue(OP_LOAD, 5'd0, 5'd0, 5'd0, 5'd0);
    issue(OP_DIVU, 5'd6, 5'd1, 5'd2, 5'd0);
    cyc(5);
    thread_active = 1'b0;
    div_wait(100, cycles, stall_ok);
    chk("fall_div_done", 32'(bus.out_valid), 32'd1);
    chk("fall_div_result", bus.result, 32'd14);
    chk("fall_div_tc", 32'(thread_complete), 32'd1);
    thread_active = 1'b1;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_lane.md
EXEC_LANE -- requirements
Module: exec_lane

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width; FADD/FSUB legal only when XLEN=32.
REQ-002 Parameter NREGS, default 32, register count; REG_AW = $clog2(NREGS), SH_W = $clog2(XLEN).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  instruction present.
REQ-006 in_ready  out  1  lane can accept; transfer when in_valid & in_ready at a rising edge.
REQ-007 opcode  in  4  operation code (see REQ-013).
REQ-008 rs1, rs2, rd  in  REG_AW each  source and destination register indices.
REQ-009 shamt  in  SH_W  shift amount for SLL/SRL.
REQ-010 init_data  in  NREGS x XLEN  bulk register image for LOAD.
REQ-011 thread_active  in  1  thread enabled.
REQ-012 out_valid  out  1, out_rd  out  REG_AW, result  out  XLEN, thread_complete  out  1, busy  out  1 (divider running).

Function
REQ-013 Opcodes: 0 ADD, 1 SUB (rs1 + ~rs2 + 1), 2 MUL (low XLEN bits), 3 DIVU (unsigned quotient), 4 FADD, 5 FSUB (rs2 sign bit inverted, then FADD), 6 SLL (rs1 << shamt), 7 SRL (rs1 >> shamt, logical), 8 LOAD, 9 HALT, 10-15 NOP.
REQ-014 Register file reads are combinational from rs1/rs2; writes occur at the acceptance edge (single-cycle ops) or the completion edge (DIVU).
REQ-015 States: IDLE, DIV; reset enters IDLE; in_ready = 1 in IDLE, 0 in DIV; busy = 1 only in DIV.
REQ-016 Single-cycle ops (ADD, SUB, MUL, FADD, FSUB, SLL, SRL) accepted in IDLE with thread_active=1: reg[rd] <= result; registered out_valid=1, out_rd=rd, result=value for exactly the following cycle.
REQ-017 Back-to-back single-cycle ops at full rate; an instruction accepted at the edge after a write reads the new value (no stale read).
REQ-018 DIVU with rs2 != 0: latch operands and rd, IDLE->DIV; restoring divide one quotient bit per cycle; after XLEN cycles in DIV write reg[rd], pulse out_valid one cycle, return to IDLE.
REQ-019 DIVU with rs2 == 0: treated as single-cycle, result all ones, no DIV entry.
REQ-020 LOAD: reg[i] <= init_data[i] for all i at acceptance edge; out_valid stays 0.
REQ-021 HALT: thread_complete <= 1; no register write; out_valid 0.
REQ-022 Any accepted non-HALT instruction with thread_active=1 clears thread_complete at its acceptance edge.
REQ-023 thread_active=0 in IDLE: in_ready=1, instructions consumed and discarded, no writes, out_valid 0, thread_complete <= 1.
REQ-024 thread_active falling during DIV: divide still completes and writes back; thread_complete <= 1 on the completion edge.
REQ-025 NOP: accepted, no state change except REQ-022.
REQ-026 Operand latching: rs1/rs2/rd changes during DIV have no effect on the running divide.

Reset
REQ-027 On rst_n low, immediately: all registers 0, state IDLE, out_valid 0, out_rd 0, result 0, busy 0, thread_complete 1.
REQ-028 Reset during DIV aborts the divide without writeback; first post-reset cycle has in_ready=1.

Structure
REQ-029 Package exec_lane_pkg holds the opcode enum, the IDLE/DIV state enum and opcode constants; parameters XLEN/NREGS stay on the module.
REQ-030 Existing add (WIDTH=XLEN) and fl32 units are instantiated for integer add/sub and float add/sub.
REQ-031 The iterative divider is a separate sub-module seq_divider (parameter XLEN; start/done handshake, quotient output).

Verification
REQ-032 LOAD with reg1=5, reg2=3; ADD rd=4 -> next cycle out_valid=1, out_rd=4, result=8; SUB rd=5 -> result=2.
REQ-033 reg1=100, reg2=7; DIVU rd=6 -> in_ready=0 and busy=1 for 32 cycles, then out_valid=1, result=14, reg6=14.
REQ-034 DIVU with reg2=0 -> result=32'hFFFFFFFF one cycle after acceptance, busy never asserted.
REQ-035 reg1=32'h3F800000, reg2=32'h40000000; FADD -> 32'h40400000; FSUB -> 32'hBF800000.
REQ-036 rst_n low 10 cycles into a DIVU -> outputs at reset values, destination register 0, thread_complete=1.
REQ-037 thread_active=0 with ADD stream -> no out_valid, registers unchanged, thread_complete=1; HALT with active=1 -> thread_complete=1.
